// File: rtl/adder_sweep_checker_if.sv
// rtl/adder_sweep_checker_if.sv - operand/sum link between the sweep checker and the adder under test
`timescale 1ns/1ps
interface adder_sweep_checker_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH:0]   sum_in;

  modport master (output a_out, output b_out, input sum_in);
  modport slave  (input a_out, input b_out, output sum_in);
endinterface

// File: rtl/adder_sweep_checker.sv
// rtl/adder_sweep_checker.sv - exhaustive sweep of every (a,b) pair through an adder, checked against a+b
`timescale 1ns/1ps
module adder_sweep_checker #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  adder_sweep_checker_if.master adder,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic                 fail_valid,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic [WIDTH:0]       fail_sum
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 start_seen;
  logic [CW-1:0]        settle_cnt;
  logic [WIDTH:0]       expected;
  logic                 mismatch;
  logic                 last_vec;
  logic                 settle_last;
  logic                 launch;
  logic [2*WIDTH-1:0]   vec_nxt;

  always_comb begin
    expected    = {1'b0, adder.a_out} + {1'b0, adder.b_out};
    mismatch    = (adder.sum_in != expected);
    last_vec    = (&adder.a_out) && (&adder.b_out);
    settle_last = (settle_cnt == CW'(SETTLE_CYCLES - 1));
    launch      = start_seen && ((state == IDLE) || (state == DONE));
    vec_nxt     = {adder.b_out, adder.a_out} + (2*WIDTH)'(1);
  end

  // start is registered, so a sweep launches one edge after start is sampled
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start_seen <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_seen <= start && ((state == IDLE) || (state == DONE));
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_nxt = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_last) state_nxt = CHECK;
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = last_vec ? DONE : SETTLE;
      end
      DONE: begin
        done = 1'b1;
        pass = (err_count == '0);
        if (launch) state_nxt = SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adder.a_out <= '0;
      adder.b_out <= '0;
      settle_cnt  <= '0;
      err_count   <= '0;
      fail_valid  <= 1'b0;
      fail_a      <= '0;
      fail_b      <= '0;
      fail_sum    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            adder.a_out <= '0;
            adder.b_out <= '0;
            settle_cnt  <= '0;
            err_count   <= '0;
            fail_valid  <= 1'b0;
            fail_a      <= '0;
            fail_b      <= '0;
            fail_sum    <= '0;
          end
        end
        SETTLE: begin
          if (!settle_last) settle_cnt <= settle_cnt + CW'(1);
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + (2*WIDTH+1)'(1);
            // only the first failing vector is kept for diagnosis
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= adder.a_out;
              fail_b     <= adder.b_out;
              fail_sum   <= adder.sum_in;
            end
          end
          if (!last_vec) {adder.b_out, adder.a_out} <= vec_nxt;
          settle_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// tb/tb_adder_sweep_checker.sv - self-checking bench for adder_sweep_checker with fault-injectable adder model
`timescale 1ns/1ps
module tb_adder_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start2;
  int   fault_mode;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  adder_sweep_checker_if #(.WIDTH(3)) bus1 ();
  adder_sweep_checker_if #(.WIDTH(3)) bus2 ();

  logic       busy, done, pass, fail_valid;
  logic [6:0] err_count;
  logic [2:0] fail_a, fail_b;
  logic [3:0] fail_sum;
  logic       busy2, done2, pass2, fail_valid2;
  logic [6:0] err_count2;
  logic [2:0] fail_a2, fail_b2;
  logic [3:0] fail_sum2;

  // mode 0 ideal, 1 sum[3] stuck 0, 2 wrong at (5,6), 3 sum[0] stuck 1, 4 wrong at (7,7)
  function automatic logic [3:0] model_sum(int mode, logic [2:0] a, logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (mode == 1) s[3] = 1'b0;
    if (mode == 2 && a == 3'd5 && b == 3'd6) s = 4'd10;
    if (mode == 3) s[0] = 1'b1;
    if (mode == 4 && a == 3'd7 && b == 3'd7) s = 4'd0;
    return s;
  endfunction

  assign bus1.sum_in = model_sum(fault_mode, bus1.a_out, bus1.b_out);
  assign bus2.sum_in = model_sum(0, bus2.a_out, bus2.b_out);

  adder_sweep_checker #(.WIDTH(3), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .adder(bus1),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b), .fail_sum(fail_sum)
  );

  adder_sweep_checker #(.WIDTH(3), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .adder(bus2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .fail_valid(fail_valid2), .fail_a(fail_a2), .fail_b(fail_b2), .fail_sum(fail_sum2)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // operand scoreboard: expected (a,b) order pushed at start, popped as the DUT presents each vector
  typedef struct packed {
    logic [2:0] b;
    logic [2:0] a;
  } op_t;
  op_t exp_q[$];
  logic       mon_seen = 1'b0;
  logic [2:0] mon_a, mon_b;

  task automatic fill_queue();
    op_t o;
    exp_q.delete();
    for (int bi = 0; bi < 8; bi++) begin
      for (int ai = 0; ai < 8; ai++) begin
        o.a = ai[2:0];
        o.b = bi[2:0];
        exp_q.push_back(o);
      end
    end
  endtask

  always @(negedge clk) begin
    op_t e;
    if (busy && !rst) begin
      if (!mon_seen || bus1.a_out != mon_a || bus1.b_out != mon_b) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_vector", {26'd0, bus1.b_out, bus1.a_out}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_operands", {26'd0, bus1.b_out, bus1.a_out}, {26'd0, e.b, e.a});
        end
      end
      mon_seen = 1'b1;
      mon_a    = bus1.a_out;
      mon_b    = bus1.b_out;
    end else begin
      mon_seen = 1'b0;
    end
  end

  task automatic pulse_start(int hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hold == 0) start = 1'b0;
  endtask

  task automatic wait_done(int hold, output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    while (edges < 1000) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges >= hold) start = 1'b0;
      if (busy) busy_n++;
      if (done) break;
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_fv"}, fail_valid, 0);
    check({tag, "_fa"}, fail_a, 0);
    check({tag, "_fb"}, fail_b, 0);
    check({tag, "_fs"}, fail_sum, 0);
    check({tag, "_a"}, bus1.a_out, 0);
    check({tag, "_b"}, bus1.b_out, 0);
  endtask

  typedef struct {
    int mode;
    int err;
    int pss;
    int fv;
    int fa;
    int fb;
    int fs;
  } vec_t;

  vec_t tbl[5];
  int   edges, busy_n;

  initial begin
    tbl[0] = '{mode: 0, err: 0,  pss: 1, fv: 0, fa: 0, fb: 0, fs: 0};
    tbl[1] = '{mode: 1, err: 28, pss: 0, fv: 1, fa: 7, fb: 1, fs: 0};
    tbl[2] = '{mode: 2, err: 1,  pss: 0, fv: 1, fa: 5, fb: 6, fs: 10};
    tbl[3] = '{mode: 3, err: 32, pss: 0, fv: 1, fa: 0, fb: 0, fs: 1};
    tbl[4] = '{mode: 4, err: 1,  pss: 0, fv: 1, fa: 7, fb: 7, fs: 0};

    rst        = 1'b1;
    start      = 1'b0;
    start2     = 1'b0;
    fault_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      fault_mode = tbl[i].mode;
      fill_queue();
      pulse_start(0);
      wait_done(0, edges, busy_n);
      check("done_edge", edges, 193);
      check("busy_cycles", busy_n, 192);
      check("err_count", err_count, tbl[i].err);
      check("pass", pass, tbl[i].pss);
      check("fail_valid", fail_valid, tbl[i].fv);
      check("fail_a", fail_a, tbl[i].fa);
      check("fail_b", fail_b, tbl[i].fb);
      check("fail_sum", fail_sum, tbl[i].fs);
      check("hold_a", bus1.a_out, 7);
      check("hold_b", bus1.b_out, 7);
      check("sb_drained", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
      check("done_held", done, 1);
    end

    // start held for 50 cycles of the sweep must not restart it
    fault_mode = 0;
    fill_queue();
    pulse_start(1);
    wait_done(50, edges, busy_n);
    check("hold_done_edge", edges, 193);
    check("hold_pass", pass, 1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_no_restart", done, 1);

    // restart from DONE clears results of a failed sweep
    fault_mode = 1;
    fill_queue();
    pulse_start(0);
    wait_done(0, edges, busy_n);
    check("pre_restart_err", err_count, 28);
    fill_queue();
    pulse_start(0);
    @(posedge clk);
    #1;
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    check("restart_err", err_count, 0);
    check("restart_fv", fail_valid, 0);
    check("restart_a", bus1.a_out, 0);
    check("restart_b", bus1.b_out, 0);
    wait_done(0, edges, busy_n);
    check("restart_done_edge", edges, 192);
    check("restart_err_end", err_count, 28);

    // reset mid-sweep, with start asserted during the reset cycle
    fill_queue();
    pulse_start(0);
    repeat (99) @(posedge clk);
    #1;
    check("mid_err_nonzero", (err_count != 0), 1);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_idle", busy, 0);
    exp_q.delete();
    fault_mode = 0;
    fill_queue();
    pulse_start(0);
    wait_done(0, edges, busy_n);
    check("fresh_done_edge", edges, 193);
    check("fresh_pass", pass, 1);
    check("fresh_err", err_count, 0);

    // single-cycle settle build
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    edges  = 0;
    while (edges < 1000) begin
      @(posedge clk);
      #1;
      edges++;
      if (done2) break;
    end
    check("s1_done_edge", edges, 129);
    check("s1_pass", pass2, 1);
    check("s1_err", err_count2, 0);
    check("s1_a", bus2.a_out, 7);
    check("s1_b", bus2.b_out, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
